// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: drives a single-beat data bus, aligns and
// extends load data, flags misaligned accesses and stalls the pipe meanwhile.
module mem_lsu #(
  parameter logic [7:0] OP_LB  = 8'hE0,
  parameter logic [7:0] OP_LBU = 8'hE4,
  parameter logic [7:0] OP_LH  = 8'hE1,
  parameter logic [7:0] OP_LHU = 8'hE5,
  parameter logic [7:0] OP_LW  = 8'hE3,
  parameter logic [7:0] OP_SB  = 8'hE8,
  parameter logic [7:0] OP_SH  = 8'hE9,
  parameter logic [7:0] OP_SW  = 8'hEB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [31:0] mem_pc,
  output logic        stall_req,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_pc,
  output logic        excp_adel,
  output logic        excp_ades,
  output logic [31:0] excp_badaddr
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic            is_load, is_store, is_byte, is_half, is_word, misaligned;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [DW-1:0]   load_data;

  logic            dbus_req_nx, dbus_we_nx;
  logic [DW-1:0]   dbus_addr_nx, dbus_wdata_nx;
  logic [3:0]      dbus_sel_nx;
  logic [RW-1:0]   wb_wd_nx;
  logic            wb_wreg_nx;
  logic [DW-1:0]   wb_wdata_nx, wb_pc_nx;
  logic            excp_adel_nx, excp_ades_nx;
  logic [DW-1:0]   excp_badaddr_nx;

  // Opcode decode and alignment check
  always_comb begin
    is_load  = (mem_aluop == OP_LB) || (mem_aluop == OP_LBU) || (mem_aluop == OP_LH) ||
               (mem_aluop == OP_LHU) || (mem_aluop == OP_LW);
    is_store = (mem_aluop == OP_SB) || (mem_aluop == OP_SH) || (mem_aluop == OP_SW);
    is_byte  = (mem_aluop == OP_LB) || (mem_aluop == OP_LBU) || (mem_aluop == OP_SB);
    is_half  = (mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH);
    is_word  = (mem_aluop == OP_LW) || (mem_aluop == OP_SW);
    misaligned = (is_half && mem_mem_addr[0]) || (is_word && (mem_mem_addr[1:0] != 2'b00));
  end

  // Lane select and extension of returned load data
  always_comb begin
    lane_byte = 8'(dbus_rdata >> {mem_mem_addr[1:0], 3'b000});
    lane_half = mem_mem_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    load_data = dbus_rdata;
    if (mem_aluop == OP_LB)       load_data = {{24{lane_byte[7]}}, lane_byte};
    else if (mem_aluop == OP_LBU) load_data = {24'd0, lane_byte};
    else if (mem_aluop == OP_LH)  load_data = {{16{lane_half[15]}}, lane_half};
    else if (mem_aluop == OP_LHU) load_data = {16'd0, lane_half};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_sel     <= '0;
      dbus_wdata   <= '0;
      wb_wd        <= '0;
      wb_wreg      <= 1'b0;
      wb_wdata     <= '0;
      wb_pc        <= '0;
      excp_adel    <= 1'b0;
      excp_ades    <= 1'b0;
      excp_badaddr <= '0;
    end else begin
      state        <= state_nx;
      dbus_req     <= dbus_req_nx;
      dbus_we      <= dbus_we_nx;
      dbus_addr    <= dbus_addr_nx;
      dbus_sel     <= dbus_sel_nx;
      dbus_wdata   <= dbus_wdata_nx;
      wb_wd        <= wb_wd_nx;
      wb_wreg      <= wb_wreg_nx;
      wb_wdata     <= wb_wdata_nx;
      wb_pc        <= wb_pc_nx;
      excp_adel    <= excp_adel_nx;
      excp_ades    <= excp_ades_nx;
      excp_badaddr <= excp_badaddr_nx;
    end
  end

  // Next state, next register values and the combinational stall
  always_comb begin
    state_nx        = state;
    stall_req       = 1'b0;
    dbus_req_nx     = dbus_req;
    dbus_we_nx      = dbus_we;
    dbus_addr_nx    = dbus_addr;
    dbus_sel_nx     = dbus_sel;
    dbus_wdata_nx   = dbus_wdata;
    wb_wd_nx        = wb_wd;
    wb_wreg_nx      = 1'b0;
    wb_wdata_nx     = wb_wdata;
    wb_pc_nx        = wb_pc;
    excp_adel_nx    = 1'b0;
    excp_ades_nx    = 1'b0;
    excp_badaddr_nx = excp_badaddr;

    case (state)
      IDLE: begin
        wb_wd_nx    = mem_wd;
        wb_wdata_nx = mem_wdata;
        wb_pc_nx    = mem_pc;
        if (!(is_load || is_store)) begin
          wb_wreg_nx = mem_wreg;
        end else if (misaligned) begin
          excp_adel_nx    = is_load;
          excp_ades_nx    = is_store;
          excp_badaddr_nx = mem_mem_addr;
        end else begin
          stall_req    = rst;
          state_nx     = BUSY;
          dbus_req_nx  = 1'b1;
          dbus_we_nx   = is_store;
          dbus_addr_nx = {mem_mem_addr[31:2], 2'b00};
          if (is_byte)      dbus_sel_nx = 4'b0001 << mem_mem_addr[1:0];
          else if (is_half) dbus_sel_nx = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
          else              dbus_sel_nx = 4'b1111;
          if (is_byte)      dbus_wdata_nx = {4{mem_reg2[7:0]}};
          else if (is_half) dbus_wdata_nx = {2{mem_reg2[15:0]}};
          else              dbus_wdata_nx = mem_reg2;
        end
      end
      BUSY: begin
        stall_req = rst;
        if (dbus_ack) begin
          state_nx    = DONE;
          dbus_req_nx = 1'b0;
          dbus_we_nx  = 1'b0;
          wb_wd_nx    = mem_wd;
          wb_pc_nx    = mem_pc;
          wb_wreg_nx  = is_load && mem_wreg;
          wb_wdata_nx = is_load ? load_data : mem_wdata;
        end
      end
      DONE: begin
        // EX/MEM advances at this edge; the held instruction is not reissued
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameters (name, default, meaning): OP_LB, 8'hE0, load byte signed; OP_LBU, 8'hE4, load byte unsigned; OP_LH, 8'hE1, load half signed; OP_LHU, 8'hE5, load half unsigned; OP_LW, 8'hE3, load word; OP_SB, 8'hE8, store byte; OP_SH, 8'hE9, store half; OP_SW, 8'hEB, store word.
REQ-002 SHALL have ports (name, direction, width, meaning):
 clk  in  1  single clock, all state changes on its rising edge
 rst  in  1  synchronous active-low reset: sampled on the rising clk edge, resets the block when 0
 mem_wd  in  5  destination register from the EX/MEM register
 mem_wreg  in  1  register-write enable
 mem_wdata  in  32  ALU result
 mem_aluop  in  8  operation code
 mem_mem_addr  in  32  effective byte address
 mem_reg2  in  32  store data
 mem_pc  in  32  instruction PC
 stall_req  out  1  hold the EX/MEM register and upstream stages
 dbus_req  out  1  data-bus request
 dbus_we  out  1  1 = write
 dbus_addr  out  32  word address, bits [1:0] = 0
 dbus_sel  out  4  byte-lane enables, bit n = bits [8n+7:8n]
 dbus_wdata  out  32  write data
 dbus_rdata  in  32  read data, valid when dbus_ack = 1
 dbus_ack  in  1  one-cycle completion
 wb_wd, wb_wreg, wb_wdata, wb_pc  out  5/1/32/32  registered results to the write-back stage
 excp_adel, excp_ades  out  1  misaligned load / store, one-cycle pulse
 excp_badaddr  out  32  faulting address

Function
REQ-003 SHALL use FSM states IDLE, BUSY, DONE.
REQ-004 Memory op SHALL mean mem_aluop equals one of OP_LB..OP_SW. Misaligned SHALL mean: halfword op with addr[0]=1, or word op with addr[1:0]!=0.
REQ-005 IDLE, non-memory op: at the edge, wb_* <= mem_*, state stays IDLE, stall_req=0.
REQ-006 IDLE, misaligned memory op: no bus access, stall_req=0, wb_wreg <= 0, excp_adel (load) or excp_ades (store) <= 1 for one cycle, excp_badaddr <= mem_mem_addr.
REQ-007 IDLE, aligned memory op: stall_req=1 (combinational), wb_wreg <= 0, state <= BUSY, and the bus outputs are loaded at the same edge.
REQ-008 Bus outputs loaded on entry to BUSY:
 - dbus_req <= 1; dbus_we <= 1 for stores; dbus_addr <= {addr[31:2],2'b00}.
 - dbus_sel: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
 - dbus_wdata: SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, SW reg2.
REQ-009 BUSY: stall_req=1; dbus_* SHALL remain stable until dbus_ack; wb_wreg <= 0 each cycle without dbus_ack.
REQ-010 BUSY with dbus_ack: at the edge, state <= DONE, dbus_req <= 0, dbus_we <= 0, wb_wd <= mem_wd, wb_pc <= mem_pc, wb_wreg <= mem_wreg for loads and 0 for stores.
REQ-011 Load data (lane selected by addr[1:0]): LB sign-extends the byte; LBU zero-extends the byte; LH sign-extends the half; LHU zero-extends the half; LW passes the whole word. Result goes to wb_wdata.
REQ-012 DONE: stall_req=0, so the EX/MEM register advances at this edge; wb_wreg <= 0; state <= IDLE. The same instruction SHALL never be issued twice.
REQ-013 dbus_ack outside BUSY SHALL be ignored.
REQ-014 Latency: a memory op SHALL occupy 2+N cycles (IDLE, N BUSY cycles with N>=1, DONE). wb is valid for exactly one cycle, in DONE.
REQ-015 Upstream SHALL hold the mem_* inputs stable while stall_req=1.

Reset
REQ-016 When rst=0 at a clock edge: state <= IDLE and every registered output <= 0. stall_req SHALL be 0 while rst=0.
REQ-017 Reset during BUSY SHALL abandon the access: dbus_req=0 after that edge, and no write-back occurs.

Verification
REQ-018 Pass-through: aluop=8'h21, wd=3, wreg=1, wdata=32'h55 -> next cycle wb_wd=3, wb_wreg=1, wb_wdata=32'h55, stall_req=0.
REQ-019 LB: addr=32'h1002, dbus_rdata=32'h00800000, ack in 2nd BUSY cycle -> dbus_addr=32'h1000, sel=4'b0100, wb_wdata=32'hFFFFFF80, stall_req high for 3 cycles, wb_wreg pulses once.
REQ-020 SH: addr=32'h2002, reg2=32'hABCD1234 -> dbus_we=1, sel=4'b1100, wdata=32'h12341234; after ack, wb_wreg=0.
REQ-021 Misaligned LW: addr=32'h3001 -> excp_adel=1 for one cycle, excp_badaddr=32'h3001, dbus_req stays 0, stall_req=0.
REQ-022 Reset mid-access: rst=0 while in BUSY -> next cycle dbus_req=0 and all outputs 0; a later dbus_ack has no effect.
REQ-023 Back-to-back: LW (ack immediate) followed by SW -> the SW request starts the cycle after DONE, and exactly one wb write occurs, for the LW.
